// File: rtl/tinyriscv_pkg.sv
// Shared pipeline-control and bus definitions for the tinyriscv front end.
package tinyriscv_pkg;

    localparam int Hold_Flag_Bus = 2;

    localparam logic [Hold_Flag_Bus-1:0] Pipe_Flow  = 2'b00;
    localparam logic [Hold_Flag_Bus-1:0] Pipe_Hold  = 2'b01;
    localparam logic [Hold_Flag_Bus-1:0] Pipe_Clear = 2'b10;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;

    // addi x0, x0, 0
    localparam logic [InstBus-1:0] InstNop = 32'h0000_0013;

    typedef enum logic {
        RUN,
        DRAIN
    } fetch_state_e;

endpackage

// File: rtl/inst_fifo_yw.sv
// Small synchronous FIFO with flush and occupancy count; head is read
// straight from storage so a pushed entry is visible the cycle after push.
module inst_fifo_yw #(
    parameter int Width = 32,
    parameter int Depth = 2,
    parameter int CntW  = $clog2(Depth) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [Width-1:0] head,
    output logic [CntW-1:0]  count
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wptr;
    logic [PtrW-1:0]  rptr;

    function automatic logic [PtrW-1:0] bump(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign head = mem[rptr];

    // Pointer and occupancy tracking; flush wins over push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= bump(wptr);
            if (pop)  rptr <= bump(rptr);
            count <= count + CntW'(push) - CntW'(pop);
        end
    end

    // Entry storage; no reset needed since count gates visibility.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit_yw.sv
// Instruction fetch front end: PC, bounded outstanding reads, instruction
// buffer and squash of stale responses after Pipe_Clear.
// Optional macro FETCH_PERF_CNT_EN adds perf_fetched_o / perf_squashed_o.
module fetch_unit_yw
    import tinyriscv_pkg::*;
#(
    parameter logic [InstAddrBus-1:0] BootAddr  = 32'h0000_0000,
    parameter int                     FifoDepth = 2,
    parameter int                     CntW      = $clog2(FifoDepth) + 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [Hold_Flag_Bus-1:0] hold_flag_i,
    input  logic                     jump_flag_i,
    input  logic [InstAddrBus-1:0]   jump_addr_i,
    output logic                     bus_req_o,
    output logic [InstAddrBus-1:0]   bus_addr_o,
    input  logic                     bus_gnt_i,
    input  logic                     bus_rvalid_i,
    input  logic [InstBus-1:0]       bus_rdata_i,
    output logic                     inst_valid_o,
    output logic [InstBus-1:0]       inst_o,
    output logic [InstAddrBus-1:0]   inst_addr_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]              perf_fetched_o,
    output logic [31:0]              perf_squashed_o
`endif
);

    localparam int EntW = InstAddrBus + InstBus;

    fetch_state_e             state;
    fetch_state_e             state_next;
    logic [InstAddrBus-1:0]   pc;
    logic [InstAddrBus-1:0]   pc_next;
    logic [CntW-1:0]          discard;
    logic [CntW-1:0]          discard_next;
    logic [CntW-1:0]          outstanding;
    logic [CntW-1:0]          fifo_count;
    logic [CntW:0]            inflight;
    logic [InstAddrBus-1:0]   tag_head;
    logic [EntW-1:0]          fifo_head;
    logic                     flush;
    logic                     grant;
    logic                     drop;
    logic                     take;
    logic                     pop;

    assign flush    = (hold_flag_i == Pipe_Clear);
    assign inflight = {1'b0, outstanding} + {1'b0, fifo_count};

    assign bus_req_o  = rst_ni && !flush && (inflight < (CntW + 1)'(FifoDepth));
    assign bus_addr_o = pc;
    assign grant      = bus_req_o && bus_gnt_i;

    // A response arriving during a clear, or while stale ones remain, is dropped.
    assign drop = bus_rvalid_i && (flush || (state == DRAIN));
    assign take = bus_rvalid_i && !drop;

    assign inst_valid_o = (fifo_count != '0);
    assign pop          = inst_valid_o && (hold_flag_i == Pipe_Flow);
    assign inst_o       = inst_valid_o ? fifo_head[InstBus-1:0] : InstNop;
    assign inst_addr_o  = inst_valid_o ? fifo_head[EntW-1:InstBus] : BootAddr;

    // Granted addresses in issue order; its occupancy is the outstanding count.
    inst_fifo_yw #(
        .Width (InstAddrBus),
        .Depth (FifoDepth),
        .CntW  (CntW)
    ) u_tag_fifo (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .flush     (1'b0),
        .push      (grant),
        .push_data (pc),
        .pop       (bus_rvalid_i),
        .head      (tag_head),
        .count     (outstanding)
    );

    inst_fifo_yw #(
        .Width (EntW),
        .Depth (FifoDepth),
        .CntW  (CntW)
    ) u_inst_fifo (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .flush     (flush),
        .push      (take),
        .push_data ({tag_head, bus_rdata_i}),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    // Next PC, discard count and fetch state.
    always_comb begin
        pc_next      = pc;
        discard_next = discard;
        if (flush) begin
            discard_next = outstanding - CntW'(bus_rvalid_i);
            if (jump_flag_i) pc_next = jump_addr_i & ~(InstAddrBus'(3));
        end else begin
            if (drop)  discard_next = discard - CntW'(1);
            if (grant) pc_next = pc + InstAddrBus'(4);
        end
        state_next = (discard_next != '0) ? DRAIN : RUN;
    end

    // Fetch state, PC and discard registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= RUN;
            pc      <= BootAddr;
            discard <= '0;
        end else begin
            state   <= state_next;
            pc      <= pc_next;
            discard <= discard_next;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [32:0] fetched_sum;
    logic [32:0] squashed_sum;

    // Saturating sums of pops and of squashed responses/entries.
    always_comb begin
        fetched_sum  = {1'b0, perf_fetched_o} + 33'(pop);
        squashed_sum = {1'b0, perf_squashed_o} + 33'(drop)
                     + (flush ? 33'(fifo_count) : 33'd0);
    end

    // Performance counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_fetched_o  <= '0;
            perf_squashed_o <= '0;
        end else begin
            perf_fetched_o  <= fetched_sum[32]  ? '1 : fetched_sum[31:0];
            perf_squashed_o <= squashed_sum[32] ? '1 : squashed_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit_yw.sv
// Directed bench for fetch_unit_yw; bus responses are driven by hand each cycle.
module tb_fetch_unit_yw;
    import tinyriscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  hold;
    logic        jump;
    logic [31:0] jaddr;
    logic        req;
    logic [31:0] baddr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ivalid;
    logic [31:0] inst;
    logic [31:0] iaddr;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_squashed;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_unit_yw dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .hold_flag_i  (hold),
        .jump_flag_i  (jump),
        .jump_addr_i  (jaddr),
        .bus_req_o    (req),
        .bus_addr_o   (baddr),
        .bus_gnt_i    (gnt),
        .bus_rvalid_i (rvalid),
        .bus_rdata_i  (rdata),
        .inst_valid_o (ivalid),
        .inst_o       (inst),
        .inst_addr_o  (iaddr)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched_o  (perf_fetched),
        .perf_squashed_o (perf_squashed)
`endif
    );

    function automatic logic [31:0] dat(input logic [31:0] a);
        return 32'hC0DE_0000 | a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] h, input logic j, input logic [31:0] ja,
                         input logic g, input logic rv, input logic [31:0] rd);
        hold = h; jump = j; jaddr = ja; gnt = g; rvalid = rv; rdata = rd;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(Pipe_Flow, 0, 0, 0, 0, 0);
        #11;
        chk("rst_req",    32'(req),    0);
        chk("rst_addr",   baddr,       32'h0);
        chk("rst_valid",  32'(ivalid), 0);
        chk("rst_inst",   inst,        InstNop);
        chk("rst_iaddr",  iaddr,       32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        // A: first request after release
        drive(Pipe_Flow, 0, 0, 1, 0, 0);
        chk("a_req",  32'(req), 1);
        chk("a_addr", baddr,    32'h0);
        tick;
        // B
        drive(Pipe_Flow, 0, 0, 1, 1, dat(32'h0));
        chk("b_req",   32'(req),    1);
        chk("b_addr",  baddr,       32'h4);
        chk("b_valid", 32'(ivalid), 0);
        tick;
        // C: first instruction visible two cycles after grant
        drive(Pipe_Flow, 0, 0, 1, 1, dat(32'h4));
        chk("c_valid", 32'(ivalid), 1);
        chk("c_iaddr", iaddr,       32'h0);
        chk("c_inst",  inst,        dat(32'h0));
        chk("c_req",   32'(req),    0);
        tick;
        // D
        drive(Pipe_Flow, 0, 0, 1, 0, 0);
        chk("d_iaddr", iaddr,    32'h4);
        chk("d_inst",  inst,     dat(32'h4));
        chk("d_req",   32'(req), 1);
        chk("d_addr",  baddr,    32'h8);
        tick;
        // E
        drive(Pipe_Flow, 0, 0, 0, 1, dat(32'h8));
        chk("e_valid", 32'(ivalid), 0);
        chk("e_addr",  baddr,       32'hC);
        tick;
        // F..J: hold for five cycles
        drive(Pipe_Hold, 0, 0, 1, 0, 0);
        chk("f_iaddr", iaddr,    32'h8);
        chk("f_req",   32'(req), 1);
        tick;
        drive(Pipe_Hold, 0, 0, 1, 1, dat(32'hC));
        chk("g_iaddr", iaddr,    32'h8);
        chk("g_req",   32'(req), 0);
        tick;
        drive(Pipe_Hold, 0, 0, 1, 0, 0);
        chk("h_req",   32'(req), 0);
        chk("h_inst",  inst,     dat(32'h8));
        tick;
        drive(Pipe_Hold, 0, 0, 1, 0, 0);
        chk("i_iaddr", iaddr,    32'h8);
        tick;
        drive(Pipe_Hold, 0, 0, 1, 0, 0);
        chk("j_inst",  inst,     dat(32'h8));
        chk("j_addr",  baddr,    32'h10);
        tick;
        // K, L: resume, nothing lost or duplicated
        drive(Pipe_Flow, 0, 0, 0, 0, 0);
        chk("k_iaddr", iaddr,    32'h8);
        chk("k_req",   32'(req), 0);
        tick;
        drive(Pipe_Flow, 0, 0, 1, 0, 0);
        chk("l_iaddr", iaddr,    32'hC);
        chk("l_inst",  inst,     dat(32'hC));
        chk("l_req",   32'(req), 1);
        tick;
        // M: second outstanding read
        drive(Pipe_Flow, 0, 0, 1, 0, 0);
        chk("m_valid", 32'(ivalid), 0);
        chk("m_addr",  baddr,       32'h14);
        tick;
        // N: clear with jump (unaligned target gets aligned)
        drive(Pipe_Clear, 1, 32'h103, 1, 0, 0);
        chk("n_req", 32'(req), 0);
        tick;
        // O, P: two stale responses dropped
        drive(Pipe_Flow, 0, 0, 1, 1, dat(32'h10));
        chk("o_addr",  baddr,       32'h100);
        chk("o_req",   32'(req),    0);
        tick;
        drive(Pipe_Flow, 0, 0, 1, 1, dat(32'h14));
        chk("p_valid", 32'(ivalid), 0);
        chk("p_req",   32'(req),    1);
        chk("p_addr",  baddr,       32'h100);
        tick;
        drive(Pipe_Flow, 0, 0, 1, 1, dat(32'h100));
        chk("q_valid", 32'(ivalid), 0);
        chk("q_addr",  baddr,       32'h104);
        tick;
        drive(Pipe_Flow, 0, 0, 0, 0, 0);
        chk("r_valid", 32'(ivalid), 1);
        chk("r_iaddr", iaddr,       32'h100);
        chk("r_inst",  inst,        dat(32'h100));
        chk("r_req",   32'(req),    0);
        tick;
        // S..W: rvalid with clear, then a second clear while draining
        drive(Pipe_Flow, 0, 0, 1, 0, 0);
        chk("s_addr", baddr, 32'h108);
        tick;
        drive(Pipe_Clear, 1, 32'h200, 1, 1, dat(32'h104));
        chk("t_req", 32'(req), 0);
        tick;
        drive(Pipe_Flow, 0, 0, 1, 0, 0);
        chk("u_req",  32'(req), 1);
        chk("u_addr", baddr,    32'h200);
        tick;
        drive(Pipe_Clear, 1, 32'h300, 1, 1, dat(32'h108));
        chk("v_valid", 32'(ivalid), 0);
        tick;
        drive(Pipe_Flow, 0, 0, 1, 1, dat(32'h200));
        chk("w_req",  32'(req), 1);
        chk("w_addr", baddr,    32'h300);
        tick;
        drive(Pipe_Flow, 0, 0, 0, 1, dat(32'h300));
        chk("x_valid", 32'(ivalid), 0);
        chk("x_addr",  baddr,       32'h304);
        tick;
        drive(Pipe_Flow, 0, 0, 0, 0, 0);
        chk("y_valid", 32'(ivalid), 1);
        chk("y_iaddr", iaddr,       32'h300);
        chk("y_inst",  inst,        dat(32'h300));
        tick;
        // Z: grant withheld for three cycles
        for (int i = 0; i < 3; i++) begin
            drive(Pipe_Flow, 0, 0, 0, 0, 0);
            chk("z_wait_addr", baddr,    32'h304);
            chk("z_wait_req",  32'(req), 1);
            tick;
        end
        drive(Pipe_Flow, 0, 0, 1, 0, 0);
        chk("z_gnt_addr", baddr, 32'h304);
        tick;
        drive(Pipe_Flow, 0, 0, 0, 1, dat(32'h304));
        chk("z_next_addr", baddr, 32'h308);
        tick;
        drive(Pipe_Flow, 0, 0, 0, 0, 0);
        chk("z_iaddr", iaddr, 32'h304);
        chk("z_inst",  inst,  dat(32'h304));
        tick;
        // Mid-flight reset
        drive(Pipe_Flow, 0, 0, 1, 0, 0);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetched",  perf_fetched,  32'd7);
        chk("perf_squashed", perf_squashed, 32'd5);
`endif
        tick;
        rst_n = 1'b0;
        #1;
        chk("mr_addr",  baddr,       32'h0);
        chk("mr_req",   32'(req),    0);
        chk("mr_valid", 32'(ivalid), 0);
`ifdef FETCH_PERF_CNT_EN
        chk("mr_perf_fetched",  perf_fetched,  32'd0);
        chk("mr_perf_squashed", perf_squashed, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        drive(Pipe_Flow, 0, 0, 0, 0, 0);
        chk("mr_rel_req",  32'(req), 1);
        chk("mr_rel_addr", baddr,    32'h0);
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
